// File: rtl/imm_gen_pkg.sv
// Shared encodings and limits for the pipelined immediate generator.
// imm_src selects the instruction format the immediate is decoded from.
package imm_gen_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_RSVD  = 3'b111;

  // Legal STAGES range is 1..MAX_STAGES.
  localparam int unsigned MAX_STAGES = 4;

endpackage

// File: rtl/imm_pipe_slice.sv
// One elastic register slice: holds a valid bit plus a data word, and accepts
// new data whenever it is empty or being drained in the same cycle.
module imm_pipe_slice
  import imm_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  assign up_ready = ~valid_q | dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (up_ready) begin
      valid_d = up_valid;
      // Data only moves on a real handshake; valid alone qualifies the output.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator: combinational decode at the input,
// then STAGES elastic slices carrying {imm_err, imm} to the execute stage.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            imm_err
);

  function automatic logic [XLEN:0] decode(input logic [31:0] ins, input logic [2:0] src);
    logic [31:0] v;
    logic        sext;
    logic        err;
    v    = '0;
    sext = 1'b1;
    err  = 1'b0;
    unique case (src)
      IMM_I: v = {{20{ins[31]}}, ins[31:20]};
      IMM_S: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U: v = {ins[31:12], 12'b0};
      IMM_J: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_SHAMT: begin
        sext = 1'b0;
        v    = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
      end
      IMM_ZIMM: begin
        sext = 1'b0;
        v    = {27'b0, ins[19:15]};
      end
      IMM_RSVD: err = 1'b1;
    endcase
    return {err, XLEN'({{32{sext & v[31]}}, v})};
  endfunction

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  logic [STAGES:0] vld;
  logic [XLEN:0]   dat [STAGES+1];

  assign vld[0] = in_valid;
  assign dat[0] = decode(instr, imm_src);

  // Ready is kept as one net per slice so the backward chain stays acyclic per signal.
  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    logic up_rdy;
    logic dn_rdy;

    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = g_slice[i+1].up_rdy;
    end

    imm_pipe_slice #(
      .WIDTH(XLEN + 1)
    ) u_slice (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .up_valid(vld[i]),
      .up_ready(up_rdy),
      .up_data (dat[i]),
      .dn_valid(vld[i+1]),
      .dn_ready(dn_rdy),
      .dn_data (dat[i+1])
    );
  end

  assign in_ready           = g_slice[0].up_rdy;
  assign out_valid          = vld[STAGES];
  assign {imm_err, imm}     = dat[STAGES];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/2-stage and a 64-bit/1-stage instance,
// directed vector tables, corner sequences and a randomized scoreboard.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        iv32, ir32, ov32, or32, err32;
  logic [31:0] imm32;
  logic        iv64, ir64, ov64, or64, err64;
  logic [63:0] imm64;

  imm_gen_pipe #(.XLEN(32), .STAGES(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32), .instr(instr),
    .imm_src(imm_src), .out_valid(ov32), .out_ready(or32), .imm(imm32), .imm_err(err32)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv64), .in_ready(ir64), .instr(instr),
    .imm_src(imm_src), .out_valid(ov64), .out_ready(or64), .imm(imm64), .imm_err(err64)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written as offsets/arithmetic on the format fields.
  function automatic logic [64:0] ref_imm(input logic [31:0] w, input logic [2:0] src,
                                          input int xlen);
    longint v;
    logic   err;
    v   = 0;
    err = 1'b0;
    case (src)
      3'd0: v = longint'($signed(w[31:20]));
      3'd1: v = longint'($signed({w[31:25], w[11:7]}));
      3'd2: v = longint'($signed({w[31], w[7], w[30:25], w[11:8]})) * 64'sd2;
      3'd3: v = longint'($signed(w[31:12])) * 64'sd4096;
      3'd4: v = longint'($signed({w[31], w[19:12], w[20], w[30:21]})) * 64'sd2;
      3'd5: v = longint'({58'b0, w[25:20]}) % longint'(xlen);
      3'd6: v = longint'({59'b0, w[19:15]});
      default: err = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {err, v};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  logic [32:0] q32[$];
  logic [64:0] q64[$];
  logic        hold32, hold64;
  logic [32:0] held32;
  logic [64:0] held64;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] w, input logic [2:0] s);
    iv32    = 1'b1;
    instr   = w;
    imm_src = s;
  endtask

  // Scoreboard update for both instances, called at the negedge of each random cycle.
  task automatic model_step();
    logic [64:0] r;
    if (hold32) begin
      check("rnd32_hold_valid", ov32, 1);
      check("rnd32_hold_data", {err32, imm32}, held32);
    end
    if (hold64) begin
      check("rnd64_hold_valid", ov64, 1);
      check("rnd64_hold_data", {err64, imm64}, held64);
    end
    if (ov32) begin
      check("rnd32_not_spurious", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        check("rnd32_data", {err32, imm32}, q32[0]);
        if (or32) void'(q32.pop_front());
      end
    end
    if (ov64) begin
      check("rnd64_not_spurious", q64.size() != 0, 1);
      if (q64.size() != 0) begin
        check("rnd64_data", {err64, imm64}, q64[0]);
        if (or64) void'(q64.pop_front());
      end
    end
    if (flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (iv32 && ir32) begin
        r = ref_imm(instr, imm_src, 32);
        q32.push_back({r[64], r[31:0]});
      end
      if (iv64 && ir64) q64.push_back(ref_imm(instr, imm_src, 64));
    end
    if (q32.size() > 2) check("rnd32_occupancy", q32.size(), 2);
    if (q64.size() > 1) check("rnd64_occupancy", q64.size(), 1);
    hold32 = ov32 && !or32 && !flush;
    hold64 = ov64 && !or64 && !flush;
    held32 = {err32, imm32};
    held64 = {err64, imm64};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got;
    tbl[0]  = '{32'hAAAAAAAA, IMM_I,     32'hFFFFFAAA, 64'hFFFFFFFF_FFFFFAAA, 1'b0};
    tbl[1]  = '{32'hAAAAAAAA, IMM_S,     32'hFFFFFAB5, 64'hFFFFFFFF_FFFFFAB5, 1'b0};
    tbl[2]  = '{32'hAAAAAAAA, IMM_B,     32'hFFFFFAB4, 64'hFFFFFFFF_FFFFFAB4, 1'b0};
    tbl[3]  = '{32'hAAAAAAAA, IMM_U,     32'hAAAAA000, 64'hFFFFFFFF_AAAAA000, 1'b0};
    tbl[4]  = '{32'hAAAAAAAA, IMM_J,     32'hFFFAA2AA, 64'hFFFFFFFF_FFFAA2AA, 1'b0};
    tbl[5]  = '{32'hAAAAAAAA, IMM_SHAMT, 32'h0000000A, 64'h00000000_0000002A, 1'b0};
    tbl[6]  = '{32'hAAAAAAAA, IMM_ZIMM,  32'h00000015, 64'h00000000_00000015, 1'b0};
    tbl[7]  = '{32'hAAAAAAAA, IMM_RSVD,  32'h00000000, 64'h00000000_00000000, 1'b1};
    tbl[8]  = '{32'h00500093, IMM_I,     32'h00000005, 64'h00000000_00000005, 1'b0};
    tbl[9]  = '{32'h00500093, IMM_SHAMT, 32'h00000005, 64'h00000000_00000005, 1'b0};
    tbl[10] = '{32'h00500093, IMM_ZIMM,  32'h00000000, 64'h00000000_00000000, 1'b0};
    tbl[11] = '{32'h00500093, IMM_RSVD,  32'h00000000, 64'h00000000_00000000, 1'b1};
    tbl[12] = '{32'h03F00000, IMM_SHAMT, 32'h0000001F, 64'h00000000_0000003F, 1'b0};
    tbl[13] = '{32'h03F00000, IMM_I,     32'h0000003F, 64'h00000000_0000003F, 1'b0};

    rst = 1'b1; flush = 1'b0; instr = '0; imm_src = IMM_I;
    iv32 = 1'b0; or32 = 1'b1; iv64 = 1'b0; or64 = 1'b1;
    hold32 = 1'b0; hold64 = 1'b0; held32 = '0; held64 = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_out_valid32", ov32, 0);
    check("reset_imm32", {err32, imm32}, 0);
    check("reset_out_valid64", ov64, 0);
    check("reset_imm64", {err64, imm64}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready32", ir32, 1);
    check("reset_in_ready64", ir64, 1);
    tick();

    // Back-to-back table stream: latency 2 on dut32, 1 on dut64, one per cycle.
    for (int k = 0; k < NVEC + 2; k++) begin
      if (k < NVEC) begin
        send32(tbl[k].instr, tbl[k].src);
        iv64 = 1'b1;
      end else begin
        iv32 = 1'b0;
        iv64 = 1'b0;
      end
      @(negedge clk);
      if (k < NVEC) check("tbl_in_ready32", ir32, 1);
      if (k >= 2) begin
        check("tbl_valid32", ov32, 1);
        check("tbl_imm32", {err32, imm32}, {tbl[k-2].err, tbl[k-2].e32});
      end else check("tbl_idle32", ov32, 0);
      if (k >= 1 && k - 1 < NVEC) begin
        check("tbl_valid64", ov64, 1);
        check("tbl_imm64", {err64, imm64}, {tbl[k-1].err, tbl[k-1].e64});
      end else check("tbl_idle64", ov64, 0);
      tick();
    end

    // Backpressure: two accepts fill the pipe, head entry stays stable.
    or32 = 1'b0;
    acc  = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) send32({12'(acc + 1), 20'h00013}, IMM_I);
      else iv32 = 1'b0;
      @(negedge clk);
      if (c >= 2) begin
        check("bp_hold_valid", ov32, 1);
        check("bp_hold_imm", imm32, 1);
        check("bp_in_ready_low", ir32, 0);
      end
      if (iv32 && ir32) acc++;
      tick();
    end
    check("bp_accept_count", acc, 2);
    or32 = 1'b1;
    got  = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (acc < 4) send32({12'(acc + 1), 20'h00013}, IMM_I);
      else iv32 = 1'b0;
      @(negedge clk);
      if (ov32) begin
        got++;
        check("bp_order", imm32, got);
      end
      if (iv32 && ir32) acc++;
      tick();
    end
    check("bp_drain_count", got, 4);
    iv32 = 1'b0;
    @(negedge clk);
    check("bp_no_duplicate", ov32, 0);
    tick();

    // Flush with two entries in flight; the flush-cycle input is discarded too.
    or32 = 1'b0;
    send32(32'h01000013, IMM_I);
    tick();
    send32(32'h02000013, IMM_I);
    tick();
    send32(32'h03000013, IMM_I);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    iv32  = 1'b0;
    or32  = 1'b1;
    @(negedge clk);
    check("flush_out_valid", ov32, 0);
    check("flush_in_ready", ir32, 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_no_stale", ov32, 0);
      tick();
    end
    send32(32'h04000013, IMM_I);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check("flush_new_valid", ov32, 1);
        check("flush_new_imm", imm32, 32'h40);
      end else check("flush_new_wait", ov32, 0);
      tick();
      iv32 = 1'b0;
    end

    // Reset with a full pipe, then a fresh entry after deassertion.
    or32 = 1'b0;
    send32(32'h05000013, IMM_I);
    tick();
    send32(32'h05000013, IMM_RSVD);
    tick();
    send32(32'h06000013, IMM_I);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    or32 = 1'b1;
    send32(32'h07000013, IMM_I);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("rst_out_valid", ov32, 0);
        check("rst_imm_err", {err32, imm32}, 0);
        check("rst_in_ready", ir32, 1);
      end
      if (k == 2) begin
        check("rst_new_valid", ov32, 1);
        check("rst_new_imm", imm32, 32'h70);
      end else check("rst_new_wait", ov32, 0);
      tick();
      iv32 = 1'b0;
    end

    // Random traffic with random backpressure and occasional flush.
    q32.delete();
    q64.delete();
    hold32 = 1'b0;
    hold64 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      iv32    = ($urandom_range(0, 3) != 0);
      or32    = ($urandom_range(0, 3) != 0);
      iv64    = ($urandom_range(0, 3) != 0);
      or64    = ($urandom_range(0, 3) != 0);
      instr   = $urandom();
      imm_src = 3'($urandom_range(0, 7));
      flush   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      model_step();
      tick();
    end
    iv32  = 1'b0;
    iv64  = 1'b0;
    or32  = 1'b1;
    or64  = 1'b1;
    flush = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      model_step();
      tick();
    end
    check("rnd32_all_drained", q32.size(), 0);
    check("rnd64_all_drained", q64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
